// File: rtl/ll_fifo_pkg.sv
// Shared helpers for the linked-list shared FIFO: width calculators and the
// reserved-capacity arithmetic used by per-queue admission.
package ll_fifo_pkg;

    function automatic int calc_ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int calc_sel_width(input int num_fifos);
        return $clog2(num_fifos);
    endfunction

    function automatic int calc_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Entries a queue still has a claim on: max(0, resv - cnt).
    function automatic int unsigned resv_shortfall(input int unsigned cnt, input int unsigned resv);
        return (cnt >= resv) ? 32'd0 : (resv - cnt);
    endfunction

endpackage

// File: rtl/ll_shared_fifo_resv_if.sv
// Request/status bundle of the shared multi-queue FIFO.
//
// Handshake: push/pop/flush are single-cycle requests sampled at posedge clk.
// A request is either accepted that cycle (state updates at the edge) or
// refused, in which case nothing changes and drop pulses for one cycle after
// the edge. full_q[push_sel] low means a push will be accepted (absent a flush
// of the same queue); data_out_vld high means a pop of pop_sel will be
// accepted (absent a flush). data_out shows the head of pop_sel with no latency.
interface ll_shared_fifo_resv_if
    import ll_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int NUM_FIFOS = 2
);
    localparam int SEL_WIDTH = calc_sel_width(NUM_FIFOS);
    localparam int CNT_WIDTH = calc_cnt_width(DEPTH);

    logic                           push;
    logic [SEL_WIDTH-1:0]           push_sel;
    logic [WIDTH-1:0]               data_in;
    logic                           pop;
    logic [SEL_WIDTH-1:0]           pop_sel;
    logic                           flush;
    logic [SEL_WIDTH-1:0]           flush_sel;
    logic [WIDTH-1:0]               data_out;
    logic                           data_out_vld;
    logic [NUM_FIFOS-1:0]           empty;
    logic [NUM_FIFOS-1:0]           full_q;
    logic                           full;
    logic [NUM_FIFOS*CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0]           free_count;
    logic                           drop;

    modport master (
        output push, push_sel, data_in, pop, pop_sel, flush, flush_sel,
        input  data_out, data_out_vld, empty, full_q, full, count, free_count, drop
    );

    modport slave (
        input  push, push_sel, data_in, pop, pop_sel, flush, flush_sel,
        output data_out, data_out_vld, empty, full_q, full, count, free_count, drop
    );

endinterface

// File: rtl/ll_free_list.sv
// Free list of the shared buffer: hands out one entry per cycle (alloc) and
// takes back either a single entry (release) or a whole chain (splice).
// Links for appended entries are emitted as a next-pointer write request.
module ll_free_list
    import ll_fifo_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PTR_WIDTH = calc_ptr_width(DEPTH),
    parameter int CNT_WIDTH = calc_cnt_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc,
    input  logic                 rel_en,
    input  logic [PTR_WIDTH-1:0] rel_idx,
    input  logic                 splice_en,
    input  logic [PTR_WIDTH-1:0] splice_head,
    input  logic [PTR_WIDTH-1:0] splice_tail,
    input  logic [CNT_WIDTH-1:0] splice_len,
    input  logic [PTR_WIDTH-1:0] head_next,
    output logic [PTR_WIDTH-1:0] free_head,
    output logic [CNT_WIDTH-1:0] free_count,
    output logic                 link_we,
    output logic [PTR_WIDTH-1:0] link_addr,
    output logic [PTR_WIDTH-1:0] link_data
);
    logic [PTR_WIDTH-1:0] free_tail;
    logic [PTR_WIDTH-1:0] app_head;
    logic [PTR_WIDTH-1:0] app_tail;
    logic [CNT_WIDTH-1:0] app_len;
    logic [CNT_WIDTH-1:0] cnt_after;
    logic                 app_en;

    // Release and splice share one append path; a release is a chain of one.
    // When the alloc empties the list, free_tail is stale, so no link is written.
    always_comb begin
        app_en    = rel_en || splice_en;
        app_head  = splice_en ? splice_head : rel_idx;
        app_tail  = splice_en ? splice_tail : rel_idx;
        app_len   = splice_en ? splice_len : CNT_WIDTH'(1);
        cnt_after = free_count - CNT_WIDTH'(alloc);
        link_we   = app_en && (cnt_after != '0);
        link_addr = free_tail;
        link_data = app_head;
    end

    // Head/tail/length registers of the free chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            free_head  <= '0;
            free_tail  <= PTR_WIDTH'(DEPTH - 1);
            free_count <= CNT_WIDTH'(DEPTH);
        end else begin
            if (app_en && (cnt_after == '0)) begin
                free_head <= app_head;
            end else if (alloc) begin
                free_head <= head_next;
            end
            if (app_en) begin
                free_tail  <= app_tail;
                free_count <= cnt_after + app_len;
            end else begin
                free_count <= cnt_after;
            end
        end
    end

endmodule

// File: rtl/ll_shared_fifo_resv.sv
// Shared-buffer multi-queue: NUM_FIFOS linked-list queues over one DEPTH-entry
// RAM, with per-queue reserved capacity, occupancy, one-cycle flush and
// hardware-refused illegal requests.
module ll_shared_fifo_resv
    import ll_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int NUM_FIFOS = 2,
    parameter int RESERVE   = 2,
    parameter int PTR_WIDTH = calc_ptr_width(DEPTH),
    parameter int SEL_WIDTH = calc_sel_width(NUM_FIFOS),
    parameter int CNT_WIDTH = calc_cnt_width(DEPTH)
) (
    input logic                 clk,
    input logic                 rst,
    ll_shared_fifo_resv_if.slave bus
);
    logic [WIDTH-1:0]     data_ram [DEPTH];
    logic [PTR_WIDTH-1:0] next_ram [DEPTH];
    logic [PTR_WIDTH-1:0] head_q   [NUM_FIFOS];
    logic [PTR_WIDTH-1:0] tail_q   [NUM_FIFOS];
    logic [CNT_WIDTH-1:0] cnt_q    [NUM_FIFOS];
    logic                 drop_q;

    int unsigned          shortfall [NUM_FIFOS];
    int unsigned          resv_total;
    logic [NUM_FIFOS-1:0] full_q;
    logic                 push_ok, pop_ok, flush_ok, drop_nxt;
    logic [NUM_FIFOS-1:0] push_hit, pop_hit, flush_hit;
    logic                 q_link_we;
    logic                 out_vld;

    logic [PTR_WIDTH-1:0] free_head;
    logic [CNT_WIDTH-1:0] free_count;
    logic                 fl_link_we;
    logic [PTR_WIDTH-1:0] fl_link_addr, fl_link_data;

    // A queue is full when the free entries left would not cover the
    // outstanding reservations of every other queue.
    always_comb begin
        resv_total = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            shortfall[i] = resv_shortfall(32'(cnt_q[i]), RESERVE);
            resv_total   = resv_total + shortfall[i];
        end
        for (int q = 0; q < NUM_FIFOS; q++) begin
            full_q[q] = (32'(free_count) <= (resv_total - shortfall[q]));
        end
    end

    // Acceptance of this cycle's requests; flush wins over pop and same-queue push.
    always_comb begin
        push_ok   = bus.push && !full_q[bus.push_sel] &&
                    !(bus.flush && (bus.flush_sel == bus.push_sel));
        pop_ok    = bus.pop && (cnt_q[bus.pop_sel] != '0) && !bus.flush;
        flush_ok  = bus.flush && (cnt_q[bus.flush_sel] != '0);
        drop_nxt  = (bus.push && !push_ok) || (bus.pop && !pop_ok);
        q_link_we = push_ok && (cnt_q[bus.push_sel] != '0);
        for (int q = 0; q < NUM_FIFOS; q++) begin
            push_hit[q]  = push_ok && (bus.push_sel == SEL_WIDTH'(q));
            pop_hit[q]   = pop_ok && (bus.pop_sel == SEL_WIDTH'(q));
            flush_hit[q] = bus.flush && (bus.flush_sel == SEL_WIDTH'(q));
        end
    end

    ll_free_list #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_free_list (
        .clk         (clk),
        .rst         (rst),
        .alloc       (push_ok),
        .rel_en      (pop_ok),
        .rel_idx     (head_q[bus.pop_sel]),
        .splice_en   (flush_ok),
        .splice_head (head_q[bus.flush_sel]),
        .splice_tail (tail_q[bus.flush_sel]),
        .splice_len  (cnt_q[bus.flush_sel]),
        .head_next   (next_ram[free_head]),
        .free_head   (free_head),
        .free_count  (free_count),
        .link_we     (fl_link_we),
        .link_addr   (fl_link_addr),
        .link_data   (fl_link_data)
    );

    // Data words are written on push only; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            data_ram[free_head] <= bus.data_in;
        end
    end

    // Next pointers: queue-tail link on push, free-tail link on release/splice.
    // The two addresses sit on different chains, so they never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                next_ram[i] <= PTR_WIDTH'((i + 1) % DEPTH);
            end
        end else begin
            if (q_link_we) begin
                next_ram[tail_q[bus.push_sel]] <= free_head;
            end
            if (fl_link_we) begin
                next_ram[fl_link_addr] <= fl_link_data;
            end
        end
    end

    // Per-queue head/tail/count and the registered drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= 1'b0;
            for (int q = 0; q < NUM_FIFOS; q++) begin
                head_q[q] <= '0;
                tail_q[q] <= '0;
                cnt_q[q]  <= '0;
            end
        end else begin
            drop_q <= drop_nxt;
            for (int q = 0; q < NUM_FIFOS; q++) begin
                if (flush_hit[q]) begin
                    cnt_q[q] <= '0;
                end else begin
                    if (pop_hit[q]) begin
                        head_q[q] <= (cnt_q[q] == CNT_WIDTH'(1)) ? free_head : next_ram[head_q[q]];
                    end else if (push_hit[q] && (cnt_q[q] == '0)) begin
                        head_q[q] <= free_head;
                    end
                    if (push_hit[q]) begin
                        tail_q[q] <= free_head;
                    end
                    cnt_q[q] <= cnt_q[q] + CNT_WIDTH'(push_hit[q]) - CNT_WIDTH'(pop_hit[q]);
                end
            end
        end
    end

    // Status and first-word fall-through read of queue pop_sel.
    always_comb begin
        out_vld           = (cnt_q[bus.pop_sel] != '0);
        bus.data_out_vld  = out_vld;
        bus.data_out      = out_vld ? data_ram[head_q[bus.pop_sel]] : '0;
        bus.full_q        = full_q;
        bus.full          = (free_count == '0);
        bus.free_count    = free_count;
        bus.drop          = drop_q;
        bus.empty         = '0;
        bus.count         = '0;
        for (int q = 0; q < NUM_FIFOS; q++) begin
            bus.empty[q]                          = (cnt_q[q] == '0);
            bus.count[q*CNT_WIDTH +: CNT_WIDTH]   = cnt_q[q];
        end
    end

endmodule

// File: tb/tb_ll_shared_fifo_resv.sv
// Bench for ll_shared_fifo_resv: directed scenarios then random traffic,
// checked against per-queue data queues and the admission rules.
module tb_ll_shared_fifo_resv;
    localparam int WIDTH   = 8;
    localparam int DEPTH   = 8;
    localparam int NF      = 2;
    localparam int RESERVE = 2;
    localparam int CW      = 4;
    localparam int SW      = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    // Reference contents of each queue, oldest first.
    logic [WIDTH-1:0] mq [NF][$];

    always #5 clk = ~clk;

    ll_shared_fifo_resv_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_FIFOS(NF)) bus ();

    ll_shared_fifo_resv #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_FIFOS(NF), .RESERVE(RESERVE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_free();
        int used = 0;
        for (int q = 0; q < NF; q++) used += mq[q].size();
        return DEPTH - used;
    endfunction

    function automatic bit m_full_q(input int q);
        int other = 0;
        for (int p = 0; p < NF; p++) begin
            if (p != q && mq[p].size() < RESERVE) other += RESERVE - mq[p].size();
        end
        return m_free() <= other;
    endfunction

    task automatic check_outputs();
        logic [NF-1:0]    e_empty;
        logic [NF-1:0]    e_fullq;
        logic [NF*CW-1:0] e_cnt;
        logic [WIDTH-1:0] e_dout;
        int ps;
        for (int q = 0; q < NF; q++) begin
            e_empty[q]         = (mq[q].size() == 0);
            e_fullq[q]         = m_full_q(q);
            e_cnt[q*CW +: CW]  = CW'(mq[q].size());
        end
        ps = int'(bus.pop_sel);
        e_dout = (mq[ps].size() != 0) ? mq[ps][0] : '0;
        check("empty", 32'(bus.empty), 32'(e_empty));
        check("full_q", 32'(bus.full_q), 32'(e_fullq));
        check("full", 32'(bus.full), 32'(m_free() == 0));
        check("count", 32'(bus.count), 32'(e_cnt));
        check("free_count", 32'(bus.free_count), 32'(m_free()));
        check("data_out_vld", 32'(bus.data_out_vld), 32'(mq[ps].size() != 0));
        check("data_out", 32'(bus.data_out), 32'(e_dout));
    endtask

    // One clock of requests: check pre-edge outputs, advance the model, check drop.
    task automatic cyc(input bit pu, input int psel, input logic [WIDTH-1:0] d,
                       input bit po, input int osel, input bit fl, input int fsel);
        bit push_ok, pop_ok, e_drop;
        @(negedge clk);
        bus.push = pu;  bus.push_sel = SW'(psel); bus.data_in = d;
        bus.pop = po;   bus.pop_sel = SW'(osel);
        bus.flush = fl; bus.flush_sel = SW'(fsel);
        #1;
        check_outputs();
        push_ok = pu && !m_full_q(psel) && !(fl && fsel == psel);
        pop_ok  = po && (mq[osel].size() != 0) && !fl;
        e_drop  = (pu && !push_ok) || (po && !pop_ok);
        if (fl) mq[fsel].delete();
        if (pop_ok) void'(mq[osel].pop_front());
        if (push_ok) mq[psel].push_back(d);
        @(posedge clk);
        #1;
        check("drop", 32'(bus.drop), 32'(e_drop));
    endtask

    task automatic idle();
        cyc(0, 0, '0, 0, 0, 0, 0);
    endtask

    // Reset for one cycle, optionally with live (ignored) requests.
    task automatic do_reset(input bit noisy);
        @(negedge clk);
        rst = 1'b1;
        bus.push = noisy; bus.push_sel = SW'($urandom_range(1, 0)); bus.data_in = WIDTH'($urandom);
        bus.pop = noisy;  bus.pop_sel = SW'($urandom_range(1, 0));
        bus.flush = 1'b0; bus.flush_sel = '0;
        @(posedge clk);
        #1;
        for (int q = 0; q < NF; q++) mq[q].delete();
        check("rst_drop", 32'(bus.drop), 32'd0);
        check("rst_free", 32'(bus.free_count), 32'd8);
        check("rst_empty", 32'(bus.empty), 32'h3);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        rst = 1'b0;
        bus.push = 1'b0; bus.pop = 1'b0;
    endtask

    initial begin
        bus.push = 1'b0; bus.push_sel = '0; bus.data_in = '0;
        bus.pop = 1'b0;  bus.pop_sel = '0;
        bus.flush = 1'b0; bus.flush_sel = '0;
        do_reset(1'b0);
        idle();

        // Fill q0 up to its share, overfill, then use q1's reserve.
        for (int i = 0; i < 6; i++) cyc(1, 0, WIDTH'(8'h11 + i), 0, 0, 0, 0);
        check("fill_free", 32'(bus.free_count), 32'd2);
        check("fill_fullq", 32'(bus.full_q), 32'h1);
        cyc(1, 0, 8'h17, 0, 0, 0, 0);
        check("overfill_drop", 32'(bus.drop), 32'd1);
        cyc(1, 1, 8'h21, 0, 0, 0, 0);
        cyc(1, 1, 8'h22, 0, 0, 0, 0);
        check("all_full", 32'(bus.full), 32'd1);
        idle();

        // In-order readback across two queues.
        do_reset(1'b0);
        cyc(1, 0, 8'hA0, 0, 0, 0, 0);
        cyc(1, 0, 8'hA1, 0, 0, 0, 0);
        cyc(1, 1, 8'hB0, 0, 0, 0, 0);
        cyc(0, 0, '0, 1, 0, 0, 0);
        cyc(0, 0, '0, 1, 0, 0, 0);
        cyc(0, 0, '0, 1, 1, 0, 0);
        idle();

        // Push and pop of a single-entry queue in one cycle.
        cyc(1, 0, 8'h55, 0, 0, 0, 0);
        cyc(1, 0, 8'h66, 1, 0, 0, 0);
        idle();
        cyc(0, 0, '0, 1, 0, 0, 0);

        // Flush q0 while pushing q1 and popping q1 (pop refused).
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) cyc(1, 0, WIDTH'(8'h30 + i), 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) cyc(1, 1, WIDTH'(8'h40 + i), 0, 0, 0, 0);
        cyc(1, 1, 8'h42, 1, 1, 1, 0);
        check("flush_pop_drop", 32'(bus.drop), 32'd1);
        idle();

        // Drain the free list, flush q1, refill from the spliced chain.
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) cyc(1, 0, WIDTH'(8'h50 + i), 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) cyc(1, 1, WIDTH'(8'h60 + i), 0, 0, 0, 0);
        cyc(0, 0, '0, 0, 0, 1, 1);
        check("splice_free", 32'(bus.free_count), 32'd2);
        cyc(1, 0, 8'h70, 0, 0, 0, 0);
        cyc(1, 1, 8'h71, 0, 1, 0, 0);
        cyc(1, 1, 8'h72, 0, 1, 0, 0);
        cyc(0, 0, '0, 1, 1, 0, 0);
        cyc(0, 0, '0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, '0, 1, 0, 0, 0);
        idle();

        // Pop on empty, then reset in the middle of traffic.
        cyc(0, 0, '0, 1, 1, 0, 0);
        check("empty_pop_drop", 32'(bus.drop), 32'd1);
        cyc(1, 0, 8'h81, 0, 0, 0, 0);
        cyc(1, 1, 8'h82, 1, 0, 0, 0);
        do_reset(1'b1);
        idle();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(99, 0) < 60, $urandom_range(1, 0), WIDTH'($urandom),
                $urandom_range(99, 0) < 45, $urandom_range(1, 0),
                $urandom_range(99, 0) < 6, $urandom_range(1, 0));
            if (n == 200) do_reset(1'b1);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
